mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//   Multi-cycle sequencer for the MIPS core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB
//   over a shared instruction/data memory port and drives the datapath mux selects and write strobes.
//   Opcode encodings: R 000000, lw 100011, sw 101011, addi 001000, andi 001100, ori 001101,
//   beq 000100, j 000001, jal 000010, jr 000011. Any other opcode is illegal.
// PARAMETERS
//   TIMEOUT  16  max consecutive cycles mem_req may wait for mem_ready before fault (>=2)
// PORTS
//   clk         in   1  single clock, rising edge
//   rst_n       in   1  asynchronous, active-low reset
//   start       in   1  run enable: sampled in IDLE and at each instruction end
//   opcode      in   6  IR[31:26]; valid from DECODE until the instruction ends
//   zero        in   1  ALU zero flag (beq)
//   mem_ready   in   1  memory completes the current request this cycle
//   mem_req     out  1  memory access request, held until mem_ready
//   mem_we      out  1  write request (sw only); valid with mem_req
//   iord        out  1  address select: 0=PC, 1=ALUOut
//   ir_write    out  1  load IR from memory read data
//   pc_write    out  1  load PC
//   pc_src      out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target, 3=rs (jr)
//   alu_src_a   out  1  0=PC, 1=rs
//   alu_src_b   out  2  0=rt, 1=const 4, 2=sext(imm), 3=sext(imm)<<2
//   alu_op      out  2  00=add, 01=sub (beq), 10=funct decode, 11=logical immediate
//   reg_write   out  1  register file write strobe
//   reg_dst     out  2  0=rt, 1=rd, 2=r31
//   mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC (link)
//   state       out  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 ERR=6
//   instr_done  out  1  1-cycle pulse in the final cycle of each instruction
//   illegal     out  1  sticky: illegal opcode seen
//   timeout     out  1  sticky: memory wait exceeded TIMEOUT
// BEHAVIOUR
//   - The state register, wait counter, illegal, and timeout are registered. All other outputs are combinational
//     from state, opcode, zero, and mem_ready. Any output not named for a state is 0 in that state.
//   - Reset: state=IDLE; wait counter, illegal, and timeout are 0. All outputs are 0 while rst_n is low.
//     A reset mid-instruction drops mem_req at once. The instruction is abandoned and there is no replay.
//   - IDLE: if start=1, go to FETCH.
//   - FETCH: mem_req=1, iord=0. On the mem_ready cycle: ir_write=1, pc_write=1, pc_src=0, alu_src_a=0,
//     alu_src_b=1 (PC+4), then go to DECODE. A zero-wait grant in the first cycle is legal.
//   - DECODE: alu_src_a=0, alu_src_b=3, alu_op=00 (branch target into ALUOut).
//     j: pc_write=1, pc_src=2, then end. jal: same as j, plus reg_write=1, reg_dst=2, mem_to_reg=2, then end.
//     jr: pc_write=1, pc_src=3, then end. Illegal opcode: set illegal, go to ERR. All others go to EXEC.
//   - EXEC: alu_src_a=1.
//     R: alu_src_b=0, alu_op=10, go to WB. addi: alu_src_b=2, alu_op=00, go to WB.
//     andi/ori: alu_src_b=2, alu_op=11, go to WB. lw/sw: alu_src_b=2, alu_op=00, go to MEM.
//     beq: alu_src_b=0, alu_op=01, pc_write=zero, pc_src=1, then end.
//   - MEM: mem_req=1, iord=1, mem_we=(sw). On mem_ready: lw goes to WB; sw ends.
//   - WB: reg_write=1, reg_dst=(R?1:0), mem_to_reg=(lw?1:0), then end.
//   - End of instruction: instr_done=1. Next state is FETCH if start=1, else IDLE.
//     A mid-instruction deassert of start never aborts the instruction.
//   - Wait counter: cleared on entry to FETCH/MEM; increments each cycle with mem_req=1 and mem_ready=0.
//     If it equals TIMEOUT-1 with mem_ready=0, set timeout and go to ERR (TIMEOUT wait cycles max).
//     mem_ready while mem_req=0 is ignored.
//   - ERR: terminal. Every strobe is 0 and the flags stay set; only rst_n exits.
//   - Cycles per instruction at zero wait: R/addi/andi/ori 4, lw 5, sw 4, beq 3, j/jal/jr 2.
//     Each wait cycle adds 1.
// TESTING
//   1. rst_n release, start=1, mem_ready=1, opcode=000000 -> state 1,2,3,5 repeating; WB has reg_write=1,
//      reg_dst=1; instr_done every 4th cycle.
//   2. lw, mem_ready low for 3 MEM cycles -> mem_req=1, iord=1, mem_we=0 for 4 cycles; WB mem_to_reg=1;
//      8 cycles total.
//   3. beq with zero=1 then zero=0 -> EXEC pc_write=1/pc_src=1 only when zero=1; 3 cycles each, no reg_write.
//   4. jal (000010) -> DECODE: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2, instr_done=1;
//      next state FETCH.
//   5. TIMEOUT=16, mem_ready stuck 0 in FETCH -> ERR after 16 cycles, timeout=1, mem_req=0;
//      only rst_n recovers.
//   6. opcode 111111 -> ERR, illegal=1. Separately, rst_n low mid-MEM -> mem_req=0 same cycle, state=IDLE,
//      flags=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared
// instruction/data memory port and drives datapath selects and strobes.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start
//   FETCH  | instruction read from PC, PC <= PC+4 on grant
//   DECODE | branch target into ALUOut; jumps finish here
//   EXEC   | ALU operation; beq finishes here
//   MEM    | data access at ALUOut; sw finishes on grant
//   WB     | register file write
//   ERR    | terminal fault (illegal opcode or memory timeout)
module mips_multicycle_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic [2:0] state,
   output logic       instr_done,
   output logic       illegal,
   output logic       timeout
);

   localparam int CW = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000001;
   localparam logic [5:0] OP_JAL  = 6'b000010;
   localparam logic [5:0] OP_JR   = 6'b000011;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t        state_q;
   logic [CW-1:0] wait_cnt;

   logic is_r, is_lw, is_sw, is_addi, is_logi, is_beq, is_j, is_jal, is_jr;
   logic is_legal, wait_hit;

   assign is_r     = (opcode == OP_R);
   assign is_lw    = (opcode == OP_LW);
   assign is_sw    = (opcode == OP_SW);
   assign is_addi  = (opcode == OP_ADDI);
   assign is_logi  = (opcode == OP_ANDI) || (opcode == OP_ORI);
   assign is_beq   = (opcode == OP_BEQ);
   assign is_j     = (opcode == OP_J);
   assign is_jal   = (opcode == OP_JAL);
   assign is_jr    = (opcode == OP_JR);
   assign is_legal = is_r | is_lw | is_sw | is_addi | is_logi | is_beq | is_j | is_jal | is_jr;

   assign state    = state_q;

   // Last permitted wait cycle: no grant now means the request has starved.
   assign wait_hit = mem_req && !mem_ready && (wait_cnt == CW'(TIMEOUT - 1));

   // Datapath controls decoded from the current state and instruction.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 2'd0;
      reg_write  = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      instr_done = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               alu_src_b = 2'd1;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'd3;
            if (is_j || is_jal) begin
               pc_write   = 1'b1;
               pc_src     = 2'd2;
               instr_done = 1'b1;
            end
            if (is_jal) begin
               reg_write  = 1'b1;
               reg_dst    = 2'd2;
               mem_to_reg = 2'd2;
            end
            if (is_jr) begin
               pc_write   = 1'b1;
               pc_src     = 2'd3;
               instr_done = 1'b1;
            end
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            if (is_r) begin
               alu_op = 2'b10;
            end else if (is_addi || is_lw || is_sw) begin
               alu_src_b = 2'd2;
            end else if (is_logi) begin
               alu_src_b = 2'd2;
               alu_op    = 2'b11;
            end else if (is_beq) begin
               alu_op     = 2'b01;
               pc_write   = zero;
               pc_src     = 2'd1;
               instr_done = 1'b1;
            end
         end
         S_MEM: begin
            mem_req    = 1'b1;
            iord       = 1'b1;
            mem_we     = is_sw;
            instr_done = mem_ready && is_sw;
         end
         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = is_r ? 2'd1 : 2'd0;
            mem_to_reg = is_lw ? 2'd1 : 2'd0;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   // Sequencing, memory wait counter and sticky fault flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wait_cnt <= '0;
         illegal  <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q  <= S_FETCH;
                  wait_cnt <= '0;
               end
            end
            S_FETCH: begin
               if (mem_ready) begin
                  state_q <= S_DECODE;
               end else if (wait_hit) begin
                  timeout <= 1'b1;
                  state_q <= S_ERR;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            S_DECODE: begin
               if (!is_legal) begin
                  illegal <= 1'b1;
                  state_q <= S_ERR;
               end else if (!(is_j || is_jal || is_jr)) begin
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_lw || is_sw) begin
                  state_q  <= S_MEM;
                  wait_cnt <= '0;
               end else if (!is_beq) begin
                  state_q <= S_WB;
               end
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (is_lw) state_q <= S_WB;
               end else if (wait_hit) begin
                  timeout <= 1'b1;
                  state_q <= S_ERR;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            S_WB: ;
            S_ERR: ;
            default: state_q <= S_ERR;
         endcase
         // Finishing an instruction overrides the per-state transition above.
         if (instr_done) begin
            state_q  <= start ? S_FETCH : S_IDLE;
            wait_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed scenarios plus a
// random instruction stream, checked cycle by cycle against an
// instruction-level model of the control sequence.
module tb_mips_multicycle_ctrl;

   localparam int TIMEOUT = 16;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000001;
   localparam logic [5:0] OP_JAL  = 6'b000010;
   localparam logic [5:0] OP_JR   = 6'b000011;

   localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                          MEM = 3'd4, WB = 3'd5, ERR = 3'd6;

   logic       clk = 1'b0;
   logic       rst_n, start, zero, mem_ready;
   logic [5:0] opcode;
   logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, reg_write;
   logic [1:0] pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
   logic [2:0] state;
   logic       instr_done, illegal, timeout;

   int   total = 0;
   int   bad   = 0;
   logic exp_ill = 1'b0;
   logic exp_to  = 1'b0;

   logic [17:0] obs;
   assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                 alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, instr_done};

   logic [5:0] legal_ops [10];

   mips_multicycle_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .state(state), .instr_done(instr_done), .illegal(illegal), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Control word the instruction's phase calls for, read straight off the
   // per-instruction step table; fields packed in the same order as obs.
   function automatic logic [17:0] exp_out(input logic [2:0] ph, input logic [5:0] op,
                                           input logic z, input logic rdy);
      logic       m_req, m_we, ad, irw, pcw, asa, rw, done;
      logic [1:0] pcs, asb, aop, rd, m2r;
      {m_req, m_we, ad, irw, pcw, asa, rw, done} = '0;
      {pcs, asb, aop, rd, m2r} = '0;
      if (ph == FETCH) begin
         m_req = 1;
         if (rdy) begin irw = 1; pcw = 1; asb = 2'd1; end
      end else if (ph == DECODE) begin
         asb = 2'd3;
         if (op == OP_J)   begin pcw = 1; pcs = 2'd2; done = 1; end
         if (op == OP_JAL) begin pcw = 1; pcs = 2'd2; done = 1; rw = 1; rd = 2'd2; m2r = 2'd2; end
         if (op == OP_JR)  begin pcw = 1; pcs = 2'd3; done = 1; end
      end else if (ph == EXEC) begin
         asa = 1;
         if (op == OP_R)    aop = 2'b10;
         if (op == OP_ADDI || op == OP_LW || op == OP_SW) asb = 2'd2;
         if (op == OP_ANDI || op == OP_ORI) begin asb = 2'd2; aop = 2'b11; end
         if (op == OP_BEQ)  begin aop = 2'b01; pcw = z; pcs = 2'd1; done = 1; end
      end else if (ph == MEM) begin
         m_req = 1; ad = 1; m_we = (op == OP_SW); done = (op == OP_SW) && rdy;
      end else if (ph == WB) begin
         rw = 1; done = 1;
         rd  = (op == OP_R)  ? 2'd1 : 2'd0;
         m2r = (op == OP_LW) ? 2'd1 : 2'd0;
      end
      return {m_req, m_we, ad, irw, pcw, pcs, asa, asb, aop, rw, rd, m2r, done};
   endfunction

   task automatic chk(input string tag, input string what, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, o, e);
      end
   endtask

   // One clock: drive inputs, check the settled outputs, advance past the edge.
   task automatic step(input logic [2:0] ph, input logic [5:0] op, input logic z,
                       input logic rdy, input logic st, input string tag);
      opcode = op; zero = z; mem_ready = rdy; start = st;
      #1;
      chk(tag, "state", 32'(state), 32'(ph));
      chk(tag, "outs",  32'(obs), 32'(exp_out(ph, op, z, rdy)));
      chk(tag, "flags", 32'({illegal, timeout}), 32'({exp_ill, exp_to}));
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'd0;
      exp_ill = 1'b0; exp_to = 1'b0;
      #1;
      chk("reset", "state", 32'(state), 32'(IDLE));
      chk("reset", "outs",  32'(obs), 32'd0);
      chk("reset", "flags", 32'({illegal, timeout}), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One instruction from its first FETCH cycle: fw/mw are memory wait
   // cycles, st_end is start in the final cycle. Leaves the DUT in FETCH.
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                            input logic z, input logic st_end, input string tag);
      logic jmp;
      jmp = (op == OP_J) || (op == OP_JAL) || (op == OP_JR);
      for (int i = 0; i <= fw; i++)
         step(FETCH, 6'($urandom), 1'($urandom), (i == fw), 1'($urandom), tag);
      step(DECODE, op, 1'($urandom), 1'($urandom), jmp ? st_end : 1'($urandom), tag);
      if (!jmp) begin
         if (op == OP_BEQ) begin
            step(EXEC, op, z, 1'($urandom), st_end, tag);
         end else begin
            step(EXEC, op, 1'($urandom), 1'($urandom), 1'($urandom), tag);
            if (op == OP_LW || op == OP_SW)
               for (int i = 0; i <= mw; i++)
                  step(MEM, op, 1'($urandom), (i == mw),
                       (i == mw && op == OP_SW) ? st_end : 1'($urandom), tag);
            if (op != OP_SW)
               step(WB, op, 1'($urandom), 1'($urandom), st_end, tag);
         end
      end
      if (!st_end)
         step(IDLE, 6'($urandom), 1'($urandom), 1'($urandom), 1'b1, tag);
   endtask

   initial begin
      legal_ops = '{OP_R, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_J, OP_JAL, OP_JR};

      do_reset();
      step(IDLE, 6'($urandom), 1'b0, 1'b1, 1'b0, "idle_hold");
      step(IDLE, 6'($urandom), 1'b0, 1'b1, 1'b1, "idle_go");

      repeat (4) run_instr(OP_R, 0, 0, 1'b0, 1'b1, "t1_r");
      run_instr(OP_LW,  0, 3, 1'b0, 1'b1, "t2_lw");
      run_instr(OP_BEQ, 0, 0, 1'b1, 1'b1, "t3_beq_z1");
      run_instr(OP_BEQ, 0, 0, 1'b0, 1'b1, "t3_beq_z0");
      run_instr(OP_JAL, 0, 0, 1'b0, 1'b1, "t4_jal");
      run_instr(OP_R,  TIMEOUT - 1, 0, 1'b0, 1'b1, "fetch_max_wait");
      run_instr(OP_SW, 0, TIMEOUT - 1, 1'b0, 1'b1, "mem_max_wait");
      run_instr(OP_ORI, 2, 0, 1'b0, 1'b0, "stop_to_idle");
      run_instr(OP_JR,  1, 0, 1'b0, 1'b0, "jr_to_idle");

      for (int n = 0; n < 150; n++)
         run_instr(legal_ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), ($urandom_range(0, 4) != 0), "rand");

      // Starved fetch: TIMEOUT wait cycles, then a sticky fault.
      for (int i = 0; i < TIMEOUT; i++)
         step(FETCH, 6'($urandom), 1'($urandom), 1'b0, 1'b1, "t5_starve");
      exp_to = 1'b1;
      repeat (3) step(ERR, OP_R, 1'b1, 1'b1, 1'b1, "t5_err");

      do_reset();
      step(IDLE, 6'd0, 1'b0, 1'b0, 1'b1, "t6_idle");
      step(FETCH, 6'd0, 1'b0, 1'b1, 1'b1, "t6_fetch");
      step(DECODE, 6'b111111, 1'b0, 1'b0, 1'b1, "t6_decode");
      exp_ill = 1'b1;
      repeat (3) step(ERR, OP_LW, 1'b0, 1'b1, 1'b1, "t6_err");

      do_reset();
      step(IDLE, 6'd0, 1'b0, 1'b0, 1'b1, "t6_rst_idle");
      step(FETCH, 6'd0, 1'b0, 1'b1, 1'b1, "t6_rst_fetch");
      step(DECODE, OP_LW, 1'b0, 1'b0, 1'b1, "t6_rst_dec");
      step(EXEC, OP_LW, 1'b0, 1'b0, 1'b1, "t6_rst_exec");
      opcode = OP_LW; mem_ready = 1'b0; #1;
      chk("t6_mid_mem", "state", 32'(state), 32'(MEM));
      chk("t6_mid_mem", "mem_req", 32'(mem_req), 32'd1);
      rst_n = 1'b0; #1;
      chk("t6_rst_async", "mem_req", 32'(mem_req), 32'd0);
      chk("t6_rst_async", "state", 32'(state), 32'(IDLE));
      chk("t6_rst_async", "flags", 32'({illegal, timeout}), 32'd0);

      do_reset();
      step(IDLE, 6'd0, 1'b0, 1'b0, 1'b1, "recover");
      run_instr(OP_ADDI, 0, 0, 1'b0, 1'b1, "recover_addi");
      run_instr(OP_J, 0, 0, 1'b0, 1'b0, "recover_j");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
